// File: rtl/scope_buffer_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scope_buffer_writer_pkg
// Description : Shared definitions for the scope display path. Holds the
//               writer FSM state encodings and the VGA geometry constants
//               that the writer and the VGA reader must agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package scope_buffer_writer_pkg;

  // Writer FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARM       = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } state_e;

  // VGA geometry shared with vga_module
  localparam int COLUMNS = 640;  // columns per capture
  localparam int ROWS    = 480;  // visible rows
  localparam int CENTER  = 240;  // row drawn for a zero sample

endpackage
`default_nettype wire

// File: rtl/sample_to_row.sv
`default_nettype none
// ============================================================================
// Module      : sample_to_row
// Description : Combinational mapping of a signed sample to a screen row:
//               arithmetic right shift, subtract from the centre row, clamp
//               to 0..ROWS-1. Larger samples are drawn higher on screen.
// Ports       : i_data  - signed two's-complement sample (D_WIDTH)
//               o_row   - clamped row index (DATA_WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sample_to_row #(
  parameter int D_WIDTH    = 24,
  parameter int DATA_WIDTH = 9,
  parameter int ROWS       = 480,
  parameter int CENTER     = 240,
  parameter int SHIFT      = 15
) (
  input  logic [D_WIDTH-1:0]    i_data,
  output logic [DATA_WIDTH-1:0] o_row
);

  // Two guard bits keep CENTER - scaled from overflowing for any input.
  localparam int                     c_y_w       = D_WIDTH + 2;
  localparam logic signed [c_y_w-1:0] c_center   = c_y_w'(CENTER);
  localparam logic signed [c_y_w-1:0] c_row_max  = c_y_w'(ROWS - 1);

  logic signed [D_WIDTH-1:0] w_scaled;
  logic signed [c_y_w-1:0]   w_y;

  assign w_scaled = $signed(i_data) >>> SHIFT;
  assign w_y      = c_center - $signed({{2{w_scaled[D_WIDTH-1]}}, w_scaled});

  always_comb begin
    o_row = w_y[DATA_WIDTH-1:0];
    if (w_y[c_y_w-1]) begin
      o_row = '0;
    end else if (w_y > c_row_max) begin
      o_row = c_row_max[DATA_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/scope_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : scope_buffer_writer
// Description : Writer side of the double-buffered VGA scope memory.
//               Decimates incoming samples, waits for a rising zero crossing
//               (or a timeout), then writes one row value per column into the
//               write bank. A full bank is handed to the reader only on a
//               frame start so the display never tears.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_data, i_dv    - sample and its 1-cycle valid strobe
//               i_enable        - capture enable level
//               i_frame_start   - 1-cycle pulse at VGA vertical sync
//               o_wr_en/bank/addr/data - RAM write port (1 clk latency)
//               o_rd_bank       - bank the VGA reader displays
//               o_busy          - high in ARM, CAPTURE or WAIT_SWAP
// Revision    : 1.0 - initial release
// ============================================================================
module scope_buffer_writer #(
  parameter int D_WIDTH      = 24,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 9,
  parameter int COLUMNS      = scope_buffer_writer_pkg::COLUMNS,
  parameter int ROWS         = scope_buffer_writer_pkg::ROWS,
  parameter int CENTER       = scope_buffer_writer_pkg::CENTER,
  parameter int SHIFT        = 15,
  parameter int DECIM        = 4,
  parameter int TRIG_TIMEOUT = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [D_WIDTH-1:0]    i_data,
  input  logic                  i_dv,
  input  logic                  i_enable,
  input  logic                  i_frame_start,
  output logic                  o_wr_en,
  output logic                  o_wr_bank,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_rd_bank,
  output logic                  o_busy
);

  import scope_buffer_writer_pkg::*;

  localparam int c_dec_w = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int c_tmo_w = $clog2(TRIG_TIMEOUT) + 1;

  state_e                  state_q;
  logic [c_dec_w-1:0]      dec_cnt_q;
  logic [c_tmo_w-1:0]      tmo_cnt_q;
  logic [ADDR_WIDTH-1:0]   col_q;
  logic                    prev_neg_q;
  logic                    prev_valid_q;
  logic                    wr_en_q;
  logic                    wr_bank_q;
  logic                    rd_bank_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  logic [DATA_WIDTH-1:0]   w_row;
  logic                    w_accept;
  logic                    w_cur_neg;
  logic                    w_trigger;
  logic                    w_timeout;
  logic                    w_last_col;

  sample_to_row #(
    .D_WIDTH    (D_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ROWS       (ROWS),
    .CENTER     (CENTER),
    .SHIFT      (SHIFT)
  ) u_sample_to_row (
    .i_data (i_data),
    .o_row  (w_row)
  );

  assign w_accept   = i_dv && (state_q != ST_IDLE) &&
                      (dec_cnt_q == c_dec_w'(DECIM - 1));
  assign w_cur_neg  = i_data[D_WIDTH-1];
  // Rising zero crossing needs a previous accepted sample in this arm period.
  assign w_trigger  = prev_valid_q && prev_neg_q && !w_cur_neg;
  assign w_timeout  = (tmo_cnt_q == c_tmo_w'(TRIG_TIMEOUT - 1));
  assign w_last_col = (col_q == ADDR_WIDTH'(COLUMNS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dec_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      col_q        <= '0;
      prev_neg_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      busy_q       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      // Write bank is always the one the reader is not showing.
      wr_bank_q <= ~rd_bank_q;

      // Decimator runs in every active state, including WAIT_SWAP, so the
      // phase is continuous into the next ARM period.
      if (state_q == ST_IDLE) begin
        dec_cnt_q <= '0;
      end else if (i_dv) begin
        dec_cnt_q <= (dec_cnt_q == c_dec_w'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          tmo_cnt_q    <= '0;
          prev_valid_q <= 1'b0;
          col_q        <= '0;
          if (i_enable) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end

        ST_ARM: begin
          if (!i_enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (w_accept) begin
            prev_neg_q   <= w_cur_neg;
            prev_valid_q <= 1'b1;
            tmo_cnt_q    <= tmo_cnt_q + 1'b1;
            if (w_trigger || w_timeout) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= w_row;
              col_q     <= ADDR_WIDTH'(1);
              state_q   <= ST_CAPTURE;
            end
          end
        end

        ST_CAPTURE: begin
          if (!i_enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (w_accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= col_q;
            wr_data_q <= w_row;
            if (w_last_col) begin
              col_q   <= '0;
              state_q <= ST_WAIT_SWAP;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end

        ST_WAIT_SWAP: begin
          if (i_frame_start) begin
            rd_bank_q    <= ~rd_bank_q;
            wr_bank_q    <= rd_bank_q;
            tmo_cnt_q    <= '0;
            prev_valid_q <= 1'b0;
            if (i_enable) begin
              state_q <= ST_ARM;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_bank = wr_bank_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_rd_bank = rd_bank_q;
  assign o_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_scope_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scope_buffer_writer
// Description : Directed self-checking bench for scope_buffer_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scope_buffer_writer;

  logic        clk;
  logic        reset;
  logic [23:0] i_data;
  logic        i_dv;
  logic        i_enable;
  logic        i_frame_start;
  logic        o_wr_en;
  logic        o_wr_bank;
  logic [9:0]  o_wr_addr;
  logic [8:0]  o_wr_data;
  logic        o_rd_bank;
  logic        o_busy;

  int checks;
  int errors;

  // Passive write monitor
  int   mon_cnt;
  int   mon_seq_bad;
  int   mon_bank_bad;
  int   mon_data_bad;
  int   mon_last_addr;
  int   mon_last_data;
  logic mon_chk_tri;

  scope_buffer_writer dut (
    .clk           (clk),
    .reset         (reset),
    .i_data        (i_data),
    .i_dv          (i_dv),
    .i_enable      (i_enable),
    .i_frame_start (i_frame_start),
    .o_wr_en       (o_wr_en),
    .o_wr_bank     (o_wr_bank),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_rd_bank     (o_rd_bank),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    mon_cnt = 0; mon_seq_bad = 0; mon_bank_bad = 0; mon_data_bad = 0;
    mon_last_addr = -1; mon_last_data = -1;
  end

  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      if (!(int'(o_wr_addr) == 0 || int'(o_wr_addr) == mon_last_addr + 1)) mon_seq_bad++;
      if (o_wr_bank === o_rd_bank) mon_bank_bad++;
      if (mon_chk_tri) begin
        if (o_wr_addr == 10'd0) begin
          if (int'(o_wr_data) != 240) mon_data_bad++;
        end else begin
          if (int'(o_wr_data) != 304 - 2 * (int'(o_wr_addr) % 64)) mon_data_bad++;
        end
      end
      mon_last_addr = int'(o_wr_addr);
      mon_last_data = int'(o_wr_data);
      mon_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decimated column: DECIM=4 back-to-back strobes of the same value.
  task automatic send_col(input logic [23:0] d, input bit fs_last);
    for (int k = 0; k < 4; k++) begin
      i_data = d;
      i_dv   = 1'b1;
      if (fs_last && k == 3) i_frame_start = 1'b1;
      tick();
      i_dv          = 1'b0;
      i_frame_start = 1'b0;
    end
  endtask

  // Triangle: (m-32)*65536 shifted by 15 gives exactly 2*(m-32).
  function automatic logic [23:0] tri_sample(input int c);
    int m;
    m = c % 64;
    return 24'((m - 32) * 65536);
  endfunction

  task automatic test_reset();
    int base;
    i_enable = 1'b1;
    tick();
    send_col(24'hFFFFFF, 1'b0);
    send_col(24'h000001, 1'b0);
    send_col(24'h000001, 1'b0);
    reset = 1'b1;
    tick(); tick(); tick();
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", o_wr_en); end
    checks++; if (o_wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got %b exp 0", o_wr_bank); end
    checks++; if (o_wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", o_wr_addr); end
    checks++; if (o_wr_data !== 9'd0) begin errors++; $display("FAIL reset_wr_data got %0d exp 0", o_wr_data); end
    checks++; if (o_rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got %b exp 0", o_rd_bank); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    i_enable = 1'b0;
    reset    = 1'b0;
    base     = mon_cnt;
    for (int k = 0; k < 40; k++) begin
      i_data = 24'(k * 1000);
      i_dv   = ~i_dv;
      tick();
    end
    i_dv = 1'b0;
    tick();
    checks++; if (mon_cnt != base) begin errors++; $display("FAIL idle_no_write got %0d writes exp 0", mon_cnt - base); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_trigger_capture();
    int base;
    int bad0;
    int bank0;
    base  = mon_cnt;
    bad0  = mon_seq_bad;
    bank0 = mon_bank_bad;
    mon_data_bad = 0;
    mon_chk_tri  = 1'b1;
    i_enable = 1'b1;
    tick();
    send_col(24'hFFFFFF, 1'b0);
    for (int c = 0; c < 640; c++) begin
      send_col((c == 0) ? 24'h000001 : tri_sample(c), c == 639);
    end
    tick();
    mon_chk_tri = 1'b0;
    checks++; if (mon_cnt - base != 640) begin errors++; $display("FAIL cap_count got %0d exp 640", mon_cnt - base); end
    checks++; if (mon_last_addr != 639) begin errors++; $display("FAIL cap_last_addr got %0d exp 639", mon_last_addr); end
    checks++; if (mon_seq_bad != bad0) begin errors++; $display("FAIL cap_addr_seq got %0d bad exp 0", mon_seq_bad - bad0); end
    checks++; if (mon_data_bad != 0) begin errors++; $display("FAIL cap_data got %0d bad exp 0", mon_data_bad); end
    checks++; if (mon_bank_bad != bank0) begin errors++; $display("FAIL cap_wr_bank got %0d bad exp 0", mon_bank_bad - bank0); end
    checks++; if (o_wr_bank !== 1'b1) begin errors++; $display("FAIL cap_wr_bank_lvl got %b exp 1", o_wr_bank); end
  endtask

  task automatic test_swap();
    // Capture ended on the same clk as a frame start: no swap yet.
    checks++; if (o_rd_bank !== 1'b0) begin errors++; $display("FAIL swap_ignored got %b exp 0", o_rd_bank); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL swap_wait_busy got %b exp 1", o_busy); end
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    tick();
    checks++; if (o_rd_bank !== 1'b1) begin errors++; $display("FAIL swap_rd_bank got %b exp 1", o_rd_bank); end
    checks++; if (o_wr_bank !== 1'b0) begin errors++; $display("FAIL swap_wr_bank got %b exp 0", o_wr_bank); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL swap_arm_busy got %b exp 1", o_busy); end
  endtask

  task automatic test_clamp();
    int base;
    base = mon_cnt;
    send_col(24'hFF8000, 1'b0);           // -32768 arms the crossing
    send_col(24'h7FFFFF, 1'b0);           // trigger, 240-255 -> 0
    tick();
    checks++; if (mon_cnt - base != 1 || mon_last_data != 0) begin errors++; $display("FAIL clamp_max got %0d exp 0", mon_last_data); end
    checks++; if (mon_last_addr != 0) begin errors++; $display("FAIL clamp_addr0 got %0d exp 0", mon_last_addr); end
    send_col(24'h800000, 1'b0);           // 240+256 -> 479
    tick();
    checks++; if (mon_last_data != 479) begin errors++; $display("FAIL clamp_min got %0d exp 479", mon_last_data); end
    send_col(24'hFF8000, 1'b0);           // 240+1 -> 241
    tick();
    checks++; if (mon_last_data != 241) begin errors++; $display("FAIL clamp_m1 got %0d exp 241", mon_last_data); end
    checks++; if (mon_last_addr != 2) begin errors++; $display("FAIL clamp_addr2 got %0d exp 2", mon_last_addr); end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop();
    int base;
    base = mon_cnt;
    i_enable = 1'b1;
    tick();
    send_col(24'hFFFFFF, 1'b0);
    for (int c = 0; c < 300; c++) send_col(24'h000001, 1'b0);
    i_enable = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", o_busy); end
    send_col(24'h000001, 1'b0);
    send_col(24'h000001, 1'b0);
    tick();
    checks++; if (mon_cnt - base != 300) begin errors++; $display("FAIL drop_count got %0d exp 300", mon_cnt - base); end
    checks++; if (mon_last_addr != 299) begin errors++; $display("FAIL drop_last_addr got %0d exp 299", mon_last_addr); end
    checks++; if (o_rd_bank !== 1'b1) begin errors++; $display("FAIL drop_no_swap got %b exp 1", o_rd_bank); end
    base = mon_cnt;
    i_enable = 1'b1;
    tick();
    send_col(24'hFFFFFF, 1'b0);
    send_col(24'h000001, 1'b0);
    tick();
    checks++; if (mon_cnt - base != 1 || mon_last_addr != 0) begin errors++; $display("FAIL reenable_addr got %0d exp 0", mon_last_addr); end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int base;
    base = mon_cnt;
    i_enable = 1'b1;
    tick();
    for (int c = 0; c < 2047; c++) send_col(24'd1000, 1'b0);
    tick();
    checks++; if (mon_cnt != base) begin errors++; $display("FAIL tmo_early got %0d writes exp 0", mon_cnt - base); end
    send_col(24'd1000, 1'b0);
    tick();
    checks++; if (mon_cnt - base != 1 || mon_last_addr != 0) begin errors++; $display("FAIL tmo_force got %0d writes exp 1", mon_cnt - base); end
    checks++; if (mon_last_data != 240) begin errors++; $display("FAIL tmo_data got %0d exp 240", mon_last_data); end
    for (int c = 1; c < 640; c++) send_col(24'd1000, 1'b0);
    tick();
    checks++; if (mon_cnt - base != 640) begin errors++; $display("FAIL tmo_count got %0d exp 640", mon_cnt - base); end
    checks++; if (mon_last_addr != 639) begin errors++; $display("FAIL tmo_last_addr got %0d exp 639", mon_last_addr); end
    // Enable falls while waiting: the swap still happens, then idle.
    i_enable = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ws_hold_busy got %b exp 1", o_busy); end
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    tick();
    checks++; if (o_rd_bank !== 1'b0) begin errors++; $display("FAIL ws_swap got %b exp 0", o_rd_bank); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ws_idle got %b exp 0", o_busy); end
    checks++; if (o_wr_bank !== 1'b1) begin errors++; $display("FAIL ws_wr_bank got %b exp 1", o_wr_bank); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    mon_chk_tri   = 1'b0;
    reset         = 1'b1;
    i_data        = '0;
    i_dv          = 1'b0;
    i_enable      = 1'b0;
    i_frame_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_trigger_capture();
    test_swap();
    test_clamp();
    test_enable_drop();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
